// File: rtl/mul_pkg.sv
// Shared encodings, FSM state type and operand helper for the iterative multiplier.
package mul_pkg;

    localparam logic [1:0] MUL_LO  = 2'b00;
    localparam logic [1:0] MUL_HSS = 2'b01;
    localparam logic [1:0] MUL_HSU = 2'b10;
    localparam logic [1:0] MUL_HUU = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_CALC = 4'b0010,
        ST_SIGN = 4'b0100,
        ST_DONE = 4'b1000
    } state_e;

    // Works on a wide container so any operand width up to 128 bits can share it;
    // the caller truncates, which keeps the low bits of the two's complement exact.
    function automatic logic [127:0] abs_if_signed(input logic [127:0] value, input logic negate);
        return negate ? (~value + 128'd1) : value;
    endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: adds the multiplicand times one multiplier digit,
// aligned to the current bit position, into the double-width accumulator.
module mul_step #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 1,
    parameter int SHIFT_W    = $clog2(2 * WIDTH)
) (
    input  logic [2*WIDTH-1:0]    acc_i,
    input  logic [WIDTH-1:0]      a_i,
    input  logic [RADIX_BITS-1:0] digit_i,
    input  logic [SHIFT_W-1:0]    shift_i,
    output logic [2*WIDTH-1:0]    acc_o
);

    logic [2*WIDTH-1:0] aWide;
    logic [2*WIDTH-1:0] partial;

    assign aWide = {{WIDTH{1'b0}}, a_i};

    // Digit times multiplicand built from per-bit shifted copies, no multiplier needed.
    always_comb begin
        partial = '0;
        for (int k = 0; k < RADIX_BITS; k++) begin
            if (digit_i[k]) begin
                partial = partial + (aWide << k);
            end
        end
        acc_o = acc_i + (partial << shift_i);
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative radix-2^R shift-add multiplier supporting MUL/MULH/MULHSU/MULHU,
// with optional early termination once the remaining multiplier bits are zero.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 1,
    parameter int EARLY_OUT  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     factor1,
    input  logic [WIDTH-1:0]     factor2,
    input  logic [1:0]           mul_op,
    input  logic                 valid,
    output logic                 ready,
    output logic                 busy,
    output logic [WIDTH-1:0]     product,
    output logic [2*WIDTH-1:0]   product_full
);

    localparam int STEPS = WIDTH / RADIX_BITS;
    localparam int CW    = $clog2(2 * WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      shift_q, shift_d;
    logic [CW-1:0]      step_q, step_d;
    logic               neg_q, neg_d;
    logic [1:0]         op_q, op_d;
    logic [2*WIDTH-1:0] full_q, full_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic               sign1, sign2;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH-1:0]   mShifted;
    logic [2*WIDTH-1:0] accNext;

    mul_step #(
        .WIDTH      (WIDTH),
        .RADIX_BITS (RADIX_BITS),
        .SHIFT_W    (CW)
    ) u_step (
        .acc_i   (acc_q),
        .a_i     (a_q),
        .digit_i (m_q[RADIX_BITS-1:0]),
        .shift_i (shift_q),
        .acc_o   (accNext)
    );

    // Operands are reduced to magnitudes up front so the datapath is purely unsigned.
    always_comb begin
        sign1    = factor1[WIDTH-1] & ((mul_op == MUL_HSS) | (mul_op == MUL_HSU));
        sign2    = factor2[WIDTH-1] & (mul_op == MUL_HSS);
        abs1     = WIDTH'(abs_if_signed(128'(factor1), sign1));
        abs2     = WIDTH'(abs_if_signed(128'(factor2), sign2));
        mShifted = m_q >> RADIX_BITS;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        acc_d   = acc_q;
        shift_d = shift_q;
        step_d  = step_q;
        neg_d   = neg_q;
        op_d    = op_q;
        full_d  = full_q;
        ready_d = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (valid && !ready_q) begin
                    a_d     = abs1;
                    m_d     = abs2;
                    neg_d   = sign1 ^ sign2;
                    op_d    = mul_op;
                    acc_d   = '0;
                    shift_d = '0;
                    step_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d   = accNext;
                m_d     = mShifted;
                shift_d = shift_q + CW'(RADIX_BITS);
                step_d  = step_q + CW'(1);
                if ((step_q == LAST_STEP) || ((EARLY_OUT != 0) && (mShifted == '0))) begin
                    state_d = ST_SIGN;
                end
            end
            ST_SIGN: begin
                full_d  = neg_q ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            shift_q <= '0;
            step_q  <= '0;
            neg_q   <= 1'b0;
            op_q    <= MUL_LO;
            full_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            shift_q <= shift_d;
            step_q  <= step_d;
            neg_q   <= neg_d;
            op_q    <= op_d;
            full_q  <= full_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign ready        = ready_q;
    assign busy         = busy_q;
    assign product_full = full_q;
    assign product      = (op_q == MUL_LO) ? full_q[WIDTH-1:0] : full_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier across several width/radix/early-out builds.
module tb_seq_multiplier;

    localparam int NDUT = 7;

    function automatic int cfgW(int g);
        case (g)
            3, 4, 6: return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int cfgR(int g);
        case (g)
            2, 4:    return 4;
            3, 5:    return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int cfgE(int g);
        case (g)
            1, 2, 4, 5: return 1;
            default:    return 0;
        endcase
    endfunction

    typedef struct {
        int          idx;
        logic [63:0] full;
        logic [31:0] prod;
        int          cycles;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     f1, f2;
    logic [1:0]      op;
    logic [NDUT-1:0] validVec, readyVec, busyVec;
    logic [31:0]     prodArr [NDUT];
    logic [63:0]     fullArr [NDUT];

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        localparam int W = cfgW(g);
        logic [W-1:0]   prodLocal;
        logic [2*W-1:0] fullLocal;

        seq_multiplier #(
            .WIDTH      (W),
            .RADIX_BITS (cfgR(g)),
            .EARLY_OUT  (cfgE(g))
        ) dut (
            .clk          (clk),
            .reset        (reset),
            .factor1      (f1[W-1:0]),
            .factor2      (f2[W-1:0]),
            .mul_op       (op),
            .valid        (validVec[g]),
            .ready        (readyVec[g]),
            .busy         (busyVec[g]),
            .product      (prodLocal),
            .product_full (fullLocal)
        );

        assign prodArr[g] = 32'(prodLocal);
        assign fullArr[g] = 64'(fullLocal);
    end

    // Golden model: sign/zero-extend to 128 bits and multiply directly.
    function automatic logic [63:0] modelFull(int w, logic [1:0] o, logic [31:0] a, logic [31:0] b);
        logic [127:0] mask, mask2, ea, eb, p;
        mask  = (128'd1 << w) - 128'd1;
        mask2 = (128'd1 << (2 * w)) - 128'd1;
        ea = 128'(a) & mask;
        eb = 128'(b) & mask;
        if ((o == 2'b01 || o == 2'b10) && a[w-1]) ea = ea | ~mask;
        if (o == 2'b01 && b[w-1]) eb = eb | ~mask;
        p = ea * eb;
        return 64'(p & mask2);
    endfunction

    function automatic logic [31:0] modelProd(int w, logic [1:0] o, logic [63:0] full);
        logic [63:0] lowMask;
        lowMask = (64'd1 << w) - 64'd1;
        if (o == 2'b00) return 32'(full & lowMask);
        return 32'((full >> w) & lowMask);
    endfunction

    // Edges from accept until ready is seen: CALC count plus SIGN and DONE.
    function automatic int expCycles(int g, logic [1:0] o, logic [31:0] b);
        int          w, r, n;
        logic [31:0] mask, absb;
        w = cfgW(g);
        r = cfgR(g);
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        absb = b & mask;
        if (o == 2'b01 && b[w-1]) absb = (~absb + 32'd1) & mask;
        if (cfgE(g) == 0) return w / r + 2;
        n = 1;
        while (n < w / r && (absb >> (n * r)) != 32'd0) n++;
        return n + 2;
    endfunction

    task automatic checkOutput(string tag, logic [127:0] obs, logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(int g, logic [1:0] o, logic [31:0] a, logic [31:0] b, bit scramble);
        exp_t e;
        int   cnt;
        bit   seen, busyOk;
        string tag;
        tag = $sformatf("dut%0d op%0d %h*%h", g, o, a, b);
        @(negedge clk);
        for (int i = 0; i < 4 && readyVec[g]; i++) @(negedge clk);
        f1 = a;
        f2 = b;
        op = o;
        validVec[g] = 1'b1;
        e.idx    = g;
        e.full   = modelFull(cfgW(g), o, a, b);
        e.prod   = modelProd(cfgW(g), o, e.full);
        e.cycles = expCycles(g, o, b);
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        validVec[g] = 1'b0;
        busyOk = busyVec[g];
        cnt    = 0;
        seen   = 1'b0;
        while (cnt < 300 && !seen) begin
            if (scramble) begin
                f1 = $urandom;
                f2 = $urandom;
                op = 2'($urandom_range(0, 3));
            end
            @(posedge clk);
            #1;
            cnt++;
            if (readyVec[g]) seen = 1'b1;
            else if (!busyVec[g]) busyOk = 1'b0;
        end
        checkOutput({tag, " ready-seen"}, 128'(seen), 128'd1);
        e = sbQ.pop_front();
        checkOutput({tag, " latency"}, 128'(cnt), 128'(e.cycles));
        checkOutput({tag, " busy-hold"}, 128'(busyOk), 128'd1);
        checkOutput({tag, " busy-clear"}, 128'(busyVec[g]), 128'd0);
        checkOutput({tag, " product"}, 128'(prodArr[e.idx]), 128'(e.prod));
        checkOutput({tag, " product_full"}, 128'(fullArr[e.idx]), 128'(e.full));
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   readyCount, k, nextEdge;
        bit   busyLow;
        exp_t e;
        logic [31:0] a, b, minv;
        int   g, sel;
        logic [1:0] o;

        reset    = 1'b1;
        validVec = '0;
        f1 = '0;
        f2 = '0;
        op = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("reset dut%0d ready", i), 128'(readyVec[i]), 128'd0);
            checkOutput($sformatf("reset dut%0d busy", i), 128'(busyVec[i]), 128'd0);
            checkOutput($sformatf("reset dut%0d product", i), 128'(prodArr[i]), 128'd0);
            checkOutput($sformatf("reset dut%0d product_full", i), 128'(fullArr[i]), 128'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(0, 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        checkOutput("mul -3x7 literal", 128'(prodArr[0]), 128'h FFFF_FFEB);
        applyStimulus(0, 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
        checkOutput("mulh min*min literal", 128'(fullArr[0]), 128'h4000_0000_0000_0000);
        applyStimulus(0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        checkOutput("mulhsu -1*max literal", 128'(fullArr[0]), 128'hFFFF_FFFF_0000_0001);
        applyStimulus(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        checkOutput("mulhu max*max literal", 128'(prodArr[0]), 128'hFFFF_FFFE);

        applyStimulus(1, 2'b11, 32'h1234_5678, 32'h0000_0003, 1'b1);
        checkOutput("early-out literal full", 128'(fullArr[1]), 128'h369D_0368);
        applyStimulus(1, 2'b00, 32'h1234_5678, 32'h0000_0000, 1'b1);
        applyStimulus(2, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Abort an operation with reset; no ready pulse may follow.
        @(negedge clk);
        f1 = 32'hFFFF_FFFD;
        f2 = 32'h0000_0007;
        op = 2'b00;
        validVec[0] = 1'b1;
        @(posedge clk);
        #1;
        validVec[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        readyCount = 0;
        busyLow = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (readyVec[0]) readyCount++;
            if (busyVec[0]) busyLow = 1'b0;
        end
        checkOutput("abort no-ready", 128'(readyCount), 128'd0);
        checkOutput("abort busy-low", 128'(busyLow), 128'd1);
        checkOutput("abort full cleared", 128'(fullArr[0]), 128'd0);
        applyStimulus(0, 2'b00, 32'd5, 32'd6, 1'b0);
        checkOutput("post-abort 5x6 literal", 128'(prodArr[0]), 128'd30);

        // Valid held high: ready pulses spaced by latency plus ignore and idle cycles.
        @(negedge clk);
        f1 = 32'h1234_5678;
        f2 = 32'h0000_0003;
        op = 2'b11;
        validVec[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e.idx    = 1;
            e.full   = modelFull(32, 2'b11, 32'h1234_5678, 32'h3);
            e.prod   = modelProd(32, 2'b11, e.full);
            e.cycles = expCycles(1, 2'b11, 32'h3);
            sbQ.push_back(e);
        end
        readyCount = 0;
        nextEdge   = 4;
        k = 0;
        while (k < 60 && readyCount < 3) begin
            @(posedge clk);
            #1;
            if (readyVec[1]) begin
                e = sbQ.pop_front();
                checkOutput($sformatf("b2b ready%0d edge", readyCount), 128'(k), 128'(nextEdge));
                checkOutput($sformatf("b2b ready%0d product", readyCount), 128'(fullArr[1]), 128'(e.full));
                readyCount++;
                nextEdge = nextEdge + e.cycles + 2;
                if (readyCount == 3) validVec[1] = 1'b0;
            end
            k++;
        end
        checkOutput("b2b pulse count", 128'(readyCount), 128'd3);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("b2b idle after drop", 128'(busyVec[1]), 128'd0);

        for (int n = 0; n < 80; n++) begin
            g    = $urandom_range(0, NDUT - 1);
            o    = 2'($urandom_range(0, 3));
            a    = $urandom;
            b    = $urandom;
            minv = 32'd1 << (cfgW(g) - 1);
            sel  = $urandom_range(0, 7);
            case (sel)
                0: b = 32'd0;
                1: a = minv;
                2: b = minv;
                3: b = $urandom_range(0, 15);
                4: a = 32'd0;
                default: ;
            endcase
            applyStimulus(g, o, a, b, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
